// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external combinational ALU: IDLE grant, EXEC capture, RESP hold-until-ready.
// Latency: accept cycle + 1 EXEC cycle, result valid 2 cycles after req_ready; requests wait while busy.
module alu_arbiter #(
    parameter int FIRST_GRANT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [2:0] req_op0,
    input  logic [2:0] req_op1,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_b1,
    output logic [1:0] req_ready,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic [2:0] alu_control,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last-grant starts as the opposite of FIRST_GRANT so the first tie goes to FIRST_GRANT.
    localparam logic LAST_INIT = (FIRST_GRANT == 0);

    state_t     state;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       g_q;
    logic       last_q;
    logic [7:0] result_q;
    logic       zero_q;
    logic [1:0] rsp_valid_q;
    logic       pick1;

    always_comb begin
        pick1 = 1'b0;
        case (req_valid)
            2'b10:   pick1 = 1'b1;
            2'b11:   pick1 = ~last_q;
            default: pick1 = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = pick1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            g_q         <= 1'b0;
            last_q      <= LAST_INIT;
            result_q    <= 8'd0;
            zero_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        op_q   <= pick1 ? req_op1 : req_op0;
                        a_q    <= pick1 ? req_a1 : req_a0;
                        b_q    <= pick1 ? req_b1 : req_b0;
                        g_q    <= pick1;
                        last_q <= pick1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    zero_q      <= alu_zero;
                    rsp_valid_q <= g_q ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready completes the handshake.
                    if (rsp_ready[g_q]) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign alu_control = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_valid   = rsp_valid_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a local ALU model; table-driven transactions plus corner sequences.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [2:0] req_op0, req_op1;
    logic [7:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic [2:0] alu_control;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.FIRST_GRANT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 000 add, 001 sub, 010 and, 011 nor, 100 xor, 101 slt, 110 pass b, 111 or.
    always_comb begin
        alu_result = 8'h00;
        case (alu_control)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = ~(alu_a | alu_b);
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = (alu_a < alu_b) ? 8'h01 : 8'h00;
            3'b110: alu_result = alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        logic [1:0] valid;
        logic [2:0] op0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [2:0] op1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       exp_g;
        logic [7:0] exp_result;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = 2'b00;
        req_op0 = 3'd0; req_a0 = 8'd0; req_b0 = 8'd0;
        req_op1 = 3'd0; req_a1 = 8'd0; req_b1 = 8'd0;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        logic [1:0] onehot;
        onehot = v.exp_g ? 2'b10 : 2'b01;
        check({tag, " idle busy"}, {7'd0, busy}, 8'h00);
        req_valid = v.valid;
        req_op0 = v.op0; req_a0 = v.a0; req_b0 = v.b0;
        req_op1 = v.op1; req_a1 = v.a1; req_b1 = v.b1;
        rsp_ready = 2'b00;
        #1;
        check({tag, " req_ready"}, {6'd0, req_ready}, {6'd0, onehot});
        step();
        req_valid = 2'b00;
        #1;
        check({tag, " exec req_ready"}, {6'd0, req_ready}, 8'h00);
        check({tag, " exec rsp_valid"}, {6'd0, rsp_valid}, 8'h00);
        check({tag, " exec alu_control"}, {5'd0, alu_control}, {5'd0, v.exp_g ? v.op1 : v.op0});
        check({tag, " exec alu_a"}, alu_a, v.exp_g ? v.a1 : v.a0);
        check({tag, " exec alu_b"}, alu_b, v.exp_g ? v.b1 : v.b0);
        step();
        check({tag, " rsp_valid"}, {6'd0, rsp_valid}, {6'd0, onehot});
        check({tag, " rsp_result"}, rsp_result, v.exp_result);
        check({tag, " rsp_zero"}, {7'd0, rsp_zero}, {7'd0, v.exp_zero});
        rsp_ready = onehot;
        step();
        rsp_ready = 2'b00;
        check({tag, " done rsp_valid"}, {6'd0, rsp_valid}, 8'h00);
        check({tag, " done busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        vec_t v;
        // Ties resolve against the last grant; reset leaves last-grant = 1 so requester 0 wins first.
        vecs[0] = '{2'b11, 3'b001, 8'h07, 8'h07, 3'b111, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{2'b11, 3'b001, 8'h07, 8'h07, 3'b111, 8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{2'b01, 3'b000, 8'h05, 8'h03, 3'b000, 8'h00, 8'h00, 1'b0, 8'h08, 1'b0};
        vecs[3] = '{2'b01, 3'b010, 8'hAA, 8'h0F, 3'b000, 8'h00, 8'h00, 1'b0, 8'h0A, 1'b0};
        vecs[4] = '{2'b10, 3'b000, 8'h00, 8'h00, 3'b100, 8'h3C, 8'h3C, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{2'b10, 3'b000, 8'h00, 8'h00, 3'b011, 8'h12, 8'h21, 1'b1, 8'hCC, 1'b0};
        vecs[6] = '{2'b11, 3'b000, 8'h80, 8'h80, 3'b001, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{2'b01, 3'b101, 8'h03, 8'h09, 3'b110, 8'h00, 8'h55, 1'b0, 8'h01, 1'b0};

        rst_n = 1'b0;
        clear_reqs();
        rsp_ready = 2'b00;
        #2;
        check("reset busy", {7'd0, busy}, 8'h00);
        check("reset rsp_valid", {6'd0, rsp_valid}, 8'h00);
        check("reset rsp_result", rsp_result, 8'h00);
        check("reset alu_a", alu_a, 8'h00);
        check("reset req_ready", {6'd0, req_ready}, 8'h00);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous tie from reset: strict alternation 0,1,0,1,0,1.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        req_valid = 2'b11;
        req_op0 = 3'b000; req_a0 = 8'h01; req_b0 = 8'h01;
        req_op1 = 3'b000; req_a1 = 8'h10; req_b1 = 8'h10;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("alt%0d req_ready", k), {6'd0, req_ready}, (k % 2 == 0) ? 8'h01 : 8'h02);
            step();
            check($sformatf("alt%0d exec rsp_valid", k), {6'd0, rsp_valid}, 8'h00);
            step();
            check($sformatf("alt%0d rsp_valid", k), {6'd0, rsp_valid}, (k % 2 == 0) ? 8'h01 : 8'h02);
            check($sformatf("alt%0d rsp_result", k), rsp_result, (k % 2 == 0) ? 8'h02 : 8'h20);
            step();
        end
        clear_reqs();
        rsp_ready = 2'b00;

        // Reset mid-EXEC aborts; rsp_result still holds 8'h20 so clearing is visible.
        req_valid = 2'b01;
        req_op0 = 3'b000; req_a0 = 8'h05; req_b0 = 8'h03;
        step();
        req_valid = 2'b00;
        #1;
        check("abort in exec busy", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("abort busy", {7'd0, busy}, 8'h00);
        check("abort rsp_valid", {6'd0, rsp_valid}, 8'h00);
        check("abort rsp_result", rsp_result, 8'h00);
        check("abort rsp_zero", {7'd0, rsp_zero}, 8'h00);
        check("abort alu_control", {5'd0, alu_control}, 8'h00);
        check("abort alu_a", alu_a, 8'h00);
        check("abort alu_b", alu_b, 8'h00);
        step();
        check("abort held rsp_valid", {6'd0, rsp_valid}, 8'h00);
        rst_n = 1'b1;
        step();
        check("post-abort rsp_valid", {6'd0, rsp_valid}, 8'h00);
        v = '{2'b01, 3'b000, 8'h05, 8'h03, 3'b000, 8'h00, 8'h00, 1'b0, 8'h08, 1'b0};
        do_txn(v, "post-abort");

        // Stalled response for requester 1; requester 0's ready must not complete it.
        req_valid = 2'b10;
        req_op1 = 3'b000; req_a1 = 8'hFF; req_b1 = 8'h01;
        #1;
        check("stall req_ready", {6'd0, req_ready}, 8'h02);
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d rsp_valid", k), {6'd0, rsp_valid}, 8'h02);
            check($sformatf("stall%0d rsp_result", k), rsp_result, 8'h00);
            check($sformatf("stall%0d rsp_zero", k), {7'd0, rsp_zero}, 8'h01);
            check($sformatf("stall%0d busy", k), {7'd0, busy}, 8'h01);
            step();
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        check("stall release busy", {7'd0, busy}, 8'h00);
        check("stall release rsp_valid", {6'd0, rsp_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
